// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // $zero is never a real dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_controller.sv
// PC-write and pipeline-buffer stall/flush sequencing for IF/ID/EX/MEM/WB.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       mem_redirect,
  input  logic       mem_access,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_we,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       stall_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic       halted
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_events
`endif
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_use;
  logic        mem_wait;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_wait = mem_access && !mem_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      RUN, DRAIN: begin
        if (mem_wait) begin
          {stall_ifid, stall_idex, stall_exmem, stall_memwb} = 4'b1111;
        end else if (mem_redirect) begin
          pc_we = 1'b1;
          {flush_ifid, flush_idex, flush_exmem} = 3'b111;
          // A redirect during drain means the halt was on the wrong path.
          state_d = RUN;
          cnt_d   = 3'd0;
        end else if (state_q == DRAIN) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (cnt_q == 3'd0) state_d = HALTED;
          else               cnt_d   = cnt_q - 3'd1;
        end else if (load_use) begin
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (halt_req) begin
          flush_ifid = 1'b1;
          cnt_d      = DRAIN_LOAD;
          state_d    = DRAIN;
        end else begin
          pc_we = 1'b1;
        end
      end
      HALTED: begin
        {stall_ifid, stall_idex, stall_exmem, stall_memwb} = 4'b1111;
        halted = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // Outputs are forced quiet for as long as reset is held, independent of the clock.
    if (!rst_b) begin
      pc_we       = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      stall_memwb = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign stall_evt = (state_q != HALTED) &&
                     (mem_wait || (state_q == RUN && !mem_redirect && load_use));
  assign flush_evt = (state_q != HALTED) && !mem_wait && mem_redirect;

  assign stall_cnt_d = (stall_evt && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_evt && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Sequences the 5-stage pipeline datapath (IF/ID/EX/MEM/WB). Generates `pc_we` and per-buffer stall/flush controls from hazard and status inputs.
- Handles four conditions: multi-cycle memory wait, taken branch/jump redirect resolved in MEM, load-use hazard in ID, and halt drain on syscall.
- Sits beside the control unit; outputs drive the datapath's PC register and pipeline buffers directly.

Parameters:
- DRAIN_CYCLES, 3, cycles after a halt is accepted before `halted` asserts (EX, MEM, WB retire).
- CNT_W, 16, width of performance counters (with the optional feature only).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt as a source.
- `ex_rd`  in  5  destination register number in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `mem_redirect`  in  1  MEM holds a taken branch, jump or jr; the PC mux selects the target.
- `mem_access`  in  1  MEM holds a load or store.
- `mem_ready`  in  1  data memory completes its access this cycle.
- `halt_req`  in  1  ID holds a syscall/halt instruction.
- `pc_we`  out  1  PC register write enable.
- `stall_ifid`, `stall_idex`, `stall_exmem`, `stall_memwb`  out  1 each  hold the buffer contents.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  load a bubble (all-zero controls).
- `halted`  out  1  sticky; the pipeline is drained.

Behaviour:
- States: RUN, DRAIN, HALTED. 3-bit drain down-counter.
- Outputs are combinational from state and current inputs. State and counter update on the rising clock edge.
- Reset (`rst_b` = 0, asynchronous):
  - state = RUN, counter = 0.
  - All outputs 0, including `pc_we` = 0.
- First cycle after reset release: normal RUN outputs.
- Condition priority, highest first: mem wait > redirect > load-use > halt.
- Mem wait: `mem_access` & !`mem_ready`.
  - `pc_we` = 0, all four stalls = 1, all flushes = 0.
  - Applies in RUN and DRAIN. In DRAIN the counter holds.
  - Unbounded; lasts until `mem_ready`.
- Redirect: `mem_redirect` with no mem wait.
  - `pc_we` = 1, `flush_ifid` = `flush_idex` = `flush_exmem` = 1, no stalls.
  - Costs exactly 3 bubbles.
  - In DRAIN: the halt was wrong-path. Return to RUN and clear the counter.
- Load-use: `ex_mem_read` & `ex_rd` != 0 & (`ex_rd` == `id_rs` | (`id_uses_rt` & `ex_rd` == `id_rt`)).
  - `pc_we` = 0, `stall_ifid` = 1, `flush_idex` = 1; other buffers advance.
  - Exactly one bubble per hazard.
- Halt, accepted only in RUN when no higher condition is active:
  - `pc_we` = 0, `flush_ifid` = 1.
  - Counter loads DRAIN_CYCLES - 1; go to DRAIN.
- DRAIN:
  - `pc_we` = 0, `flush_ifid` = 1, `flush_idex` = 1 (no new issue). EX/MEM/WB advance.
  - Counter decrements each non-waiting cycle.
  - At counter = 0 with no mem wait: go to HALTED.
- HALTED: `pc_we` = 0, all stalls = 1, `halted` = 1. Exit only by reset.
- `halt_req` together with a load-use hazard: load-use wins. Halt is retried next cycle.
- `ex_rd` = 0 never causes a stall.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- With the macro defined, add outputs:
  - `stall_cycles` [CNT_W]: increments on mem-wait or load-use cycles.
  - `flush_events` [CNT_W]: increments per redirect.
  - Both saturate at all-ones, reset to 0, and freeze in HALTED.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum `ctrl_state_e` {RUN, DRAIN, HALTED}.
  - REG_ZERO = 5'd0.
  - Default DRAIN_CYCLES constant.
- One sub-module: `hazard_detect`, the combinational load-use comparator producing `load_use`.
- FSM and output encoding stay in the top module.

Test Plan:
- lw $2 in EX (`ex_rd` = 2, `ex_mem_read` = 1), ID `id_rs` = 2 -> one cycle with `pc_we` = 0, `stall_ifid` = 1, `flush_idex` = 1; next cycle normal. Repeat with `ex_rd` = 0 -> no stall.
- `mem_redirect` = 1 for one cycle -> `pc_we` = 1 and `flush_ifid`/`flush_idex`/`flush_exmem` = 1 for that cycle only. Also `stall_cycles` unchanged and `flush_events` +1 when PIPE_PERF_CNT_EN is defined.
- `mem_access` = 1, `mem_ready` low for 4 cycles with `mem_redirect` = 1 -> 4 cycles all stalls = 1, `pc_we` = 0, no flush; 5th cycle the redirect takes effect.
- `halt_req` pulse in RUN, no other events -> DRAIN for 3 cycles, `halted` = 1 on the 4th cycle and stays high for 10+ cycles.
- `halt_req` accepted, then `mem_redirect` 1 cycle later -> state returns to RUN, `halted` never asserts, `pc_we` = 1.
- Assert `rst_b` low mid-DRAIN (asynchronously, between edges) -> all outputs 0 immediately. After release, state RUN and `halted` = 0.
